// File: rtl/mssd_framer.sv
// mssd_framer: turns one parallel request into a framed serial stream for the MSSD demux.
// Frame on serOut: start(0), port MSB first, len MSB first, payload LSB first, then guard high.
module mssd_framer #(
   parameter int LEN_W        = 4,
   parameter int GUARD_CYCLES = 1
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_port,
   input  logic [LEN_W-1:0]      in_len,
   input  logic [(2**LEN_W)-1:0] in_data,
   output logic                  serOut,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int DATA_W = 2**LEN_W;
   localparam int CNT_W  = (LEN_W > 4) ? LEN_W : 4;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_LEN   = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_GUARD = 3'd5;

   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_port;
   logic [LEN_W-1:0]  r_len;
   logic [DATA_W-1:0] r_data;
   logic              r_ser;
   logic              r_busy;
   logic              r_ready;
   logic              r_done;
   logic              w_cnt_zero;

   assign w_cnt_zero = (r_cnt == '0);

   // r_state names the field currently on the line; each edge loads the next bit.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_port  <= '0;
         r_len   <= '0;
         r_data  <= '0;
         r_ser   <= 1'b1;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ser   <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               if (in_valid && r_ready) begin
                  r_port  <= in_port;
                  r_len   <= in_len;
                  r_data  <= in_data;
                  r_state <= S_START;
                  r_ser   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
               end
            end
            S_START: begin
               r_state <= S_ADDR;
               r_ser   <= r_port[1];
               r_cnt   <= CNT_W'(1);
            end
            S_ADDR: begin
               if (!w_cnt_zero) begin
                  r_ser <= r_port[0];
                  r_cnt <= '0;
               end else begin
                  r_state <= S_LEN;
                  r_ser   <= r_len[LEN_W-1];
                  r_len   <= {r_len[LEN_W-2:0], r_len[LEN_W-1]};
                  r_cnt   <= CNT_W'(LEN_W - 1);
               end
            end
            S_LEN: begin
               // Rotating LEN_W times leaves r_len intact for the payload counter load.
               if (!w_cnt_zero) begin
                  r_ser <= r_len[LEN_W-1];
                  r_len <= {r_len[LEN_W-2:0], r_len[LEN_W-1]};
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state <= S_DATA;
                  r_ser   <= r_data[0];
                  r_data  <= r_data >> 1;
                  r_cnt   <= CNT_W'(r_len);
               end
            end
            S_DATA: begin
               if (!w_cnt_zero) begin
                  r_ser  <= r_data[0];
                  r_data <= r_data >> 1;
                  r_cnt  <= r_cnt - CNT_W'(1);
               end else begin
                  r_state <= S_GUARD;
                  r_ser   <= 1'b1;
                  r_done  <= 1'b1;
                  r_cnt   <= CNT_W'(GUARD_CYCLES - 1);
               end
            end
            S_GUARD: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ser   <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = r_ready;
   assign serOut     = r_ser;
   assign busy       = r_busy;
   assign frame_done = r_done;

endmodule

// File: tb/tb_mssd_framer.sv
// Directed bench for mssd_framer: frame contents, timing, back-to-back, isolation, reset, guard width.
module tb_mssd_framer;

   logic        Clk;
   logic        reset;
   logic        in_valid;
   logic        in_valid3;
   logic [1:0]  in_port;
   logic [3:0]  in_len;
   logic [15:0] in_data;
   logic        so1, rdy1, busy1, done1;
   logic        so3, rdy3, busy3, done3;

   int n_checks = 0;
   int n_fail   = 0;

   mssd_framer #(.LEN_W(4), .GUARD_CYCLES(1)) u_dut (
      .Clk        (Clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (rdy1),
      .in_port    (in_port),
      .in_len     (in_len),
      .in_data    (in_data),
      .serOut     (so1),
      .busy       (busy1),
      .frame_done (done1)
   );

   mssd_framer #(.LEN_W(4), .GUARD_CYCLES(3)) u_dut_g3 (
      .Clk        (Clk),
      .reset      (reset),
      .in_valid   (in_valid3),
      .in_ready   (rdy3),
      .in_port    (in_port),
      .in_len     (in_len),
      .in_data    (in_data),
      .serOut     (so3),
      .busy       (busy3),
      .frame_done (done3)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected line value in cycle k (1-based) after acceptance, within the frame.
   function automatic logic exp_bit(input logic [1:0] p, input logic [3:0] l,
                                    input logic [15:0] d, input int k);
      if (k == 1) return 1'b0;
      if (k == 2) return p[1];
      if (k == 3) return p[0];
      if (k <= 7) return l[2'(7 - k)];
      return d[4'(k - 8)];
   endfunction

   task automatic send(input int sel, input logic [1:0] p, input logic [3:0] l, input logic [15:0] d);
      @(negedge Clk);
      in_port = p;
      in_len  = l;
      in_data = d;
      if (sel == 0) in_valid = 1'b1;
      else          in_valid3 = 1'b1;
      check_val("ready_before_req", (sel == 0) ? rdy1 : rdy3, 1);
      @(posedge Clk);
      #1;
   endtask

   // Called just after the acceptance edge; ends at the negedge of the in_ready-high cycle.
   task automatic run_frame(input int sel, input logic [1:0] p, input logic [3:0] l,
                            input logic [15:0] d, input int g, input bit scramble,
                            input bit hold_valid);
      int flen;
      logic so, rdy, bsy, dn;
      flen = 8 + int'(l);
      for (int k = 1; k <= flen + g + 1; k++) begin
         @(negedge Clk);
         if (k == 1 && !hold_valid) begin
            in_valid  = 1'b0;
            in_valid3 = 1'b0;
         end
         so  = (sel == 0) ? so1   : so3;
         rdy = (sel == 0) ? rdy1  : rdy3;
         bsy = (sel == 0) ? busy1 : busy3;
         dn  = (sel == 0) ? done1 : done3;
         check_val($sformatf("serOut p%0d l%0d k%0d", p, l, k), so,
                   (k <= flen) ? exp_bit(p, l, d, k) : 1'b1);
         check_val($sformatf("busy k%0d", k), bsy, (k <= flen + g) ? 1 : 0);
         check_val($sformatf("in_ready k%0d", k), rdy, (k == flen + g + 1) ? 1 : 0);
         check_val($sformatf("frame_done k%0d", k), dn, (k == flen + 1) ? 1 : 0);
         if (scramble) begin
            in_port = 2'($urandom);
            in_len  = 4'($urandom);
            in_data = 16'($urandom);
            in_valid = (k < flen + g + 1) ? 1'($urandom) : 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_valid3 = 1'b0;
      in_port   = '0;
      in_len    = '0;
      in_data   = '0;

      // Reset state
      #12;
      check_val("rst serOut", so1, 1);
      check_val("rst in_ready", rdy1, 0);
      check_val("rst busy", busy1, 0);
      check_val("rst frame_done", done1, 0);
      check_val("rst g3 in_ready", rdy3, 0);
      @(negedge Clk);
      reset = 1'b1;
      @(negedge Clk);
      check_val("ready after release", rdy1, 1);
      check_val("ready after release g3", rdy3, 1);

      // Basic frame: 0,1,0,0,0,1,1,1,1,0,1
      send(0, 2'd2, 4'd3, 16'h000B);
      run_frame(0, 2'd2, 4'd3, 16'h000B, 1, 0, 0);

      // Minimum length: upper payload bits never appear
      send(0, 2'd3, 4'd0, 16'hFFFE);
      run_frame(0, 2'd3, 4'd0, 16'hFFFE, 1, 0, 0);

      // Maximum length with a second request held behind it
      send(0, 2'd1, 4'd15, 16'hA5A5);
      in_port = 2'd2;
      in_len  = 4'd1;
      in_data = 16'h0002;
      run_frame(0, 2'd1, 4'd15, 16'hA5A5, 1, 0, 1);
      @(posedge Clk);
      #1;
      in_valid = 1'b0;
      run_frame(0, 2'd2, 4'd1, 16'h0002, 1, 0, 0);

      // Input isolation: inputs churn and in_valid pulses while busy
      send(0, 2'd0, 4'd5, 16'h1234);
      run_frame(0, 2'd0, 4'd5, 16'h1234, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check_val($sformatf("no extra frame busy %0d", i), busy1, 0);
         check_val($sformatf("no extra frame serOut %0d", i), so1, 1);
      end

      // Reset during payload cycle 2 (line carries data[1]=0 there)
      send(0, 2'd2, 4'd3, 16'h000D);
      in_valid = 1'b0;
      for (int k = 1; k <= 9; k++) @(negedge Clk);
      check_val("pre-reset serOut", so1, 0);
      check_val("pre-reset busy", busy1, 1);
      reset = 1'b0;
      #1;
      check_val("midreset serOut", so1, 1);
      check_val("midreset busy", busy1, 0);
      check_val("midreset in_ready", rdy1, 0);
      check_val("midreset frame_done", done1, 0);
      @(negedge Clk);
      @(negedge Clk);
      reset = 1'b1;
      @(negedge Clk);
      check_val("ready after midreset", rdy1, 1);
      check_val("idle after midreset", busy1, 0);
      send(0, 2'd2, 4'd3, 16'h000B);
      run_frame(0, 2'd2, 4'd3, 16'h000B, 1, 0, 0);

      // Guard of 3 cycles on the second instance
      send(1, 2'd1, 4'd2, 16'h0005);
      run_frame(1, 2'd1, 4'd2, 16'h0005, 3, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
